lc3_mem_io: RTL and testbench
=============================

// Module: lc3_mem_io
// PURPOSE
//  Memory/IO stage below the LC-3 datapath: accepts MIO_EN/R_W requests at MAR/MDR, runs a
//  multi-cycle main-memory access, returns read data and the R (ready) flag to the
//  microsequencer. Decodes LC-3 device registers KBSR/KBDR/DSR/DDR/MCR and raises the
//  keyboard interrupt request (INT) consumed by control.
// PARAMETERS
//  MEM_LATENCY  3     cycles from request acceptance to r pulse for main memory (>=1)
//  MEM_WORDS    4096  main-memory words; address taken modulo MEM_WORDS (power of 2)
// PORTS
//  clk        in   1   single clock, all state on posedge
//  reset      in   1   synchronous, active-high
//  mio_en     in   1   memory/IO request (control word MIO_EN)
//  r_w        in   1   1 = write, 0 = read
//  mar        in   16  access address
//  mdr_in     in   16  write data
//  mem_out    out  16  read data; valid when r=1, held until next read completes
//  r          out  1   ready; one-cycle pulse per completed access
//  kb_valid   in   1   keyboard char available
//  kb_data    in   8   keyboard char
//  kb_ready   out  1   keyboard char accepted (= ~KBSR[15])
//  disp_valid out  1   display char pending
//  disp_data  out  8   display char (DDR[7:0])
//  disp_ready in   1   display consumed char when disp_valid & disp_ready
//  int_req    out  1   keyboard interrupt = KBSR[15] & KBSR[14]
//  mcr_run    out  1   MCR[15]; machine halts when 0
// BEHAVIOUR
//  Reset: state IDLE, r=0, mem_out=0, KBSR=0, KBDR=0, DSR=16'h8000, DDR=0, MCR=16'h8000,
//   disp_valid=0, int_req=0, mcr_run=1. Memory array is not cleared.
//  Device map: KBSR xFE00, KBDR xFE02, DSR xFE04, DDR xFE06, MCR xFFFE; other xFE00-xFFFF
//   addresses read 0, writes ignored; below xFE00 = main memory.
//  FSM IDLE/BUSY:
//   IDLE, mio_en=1: latch mar, mdr_in, r_w. Device address -> access performed at that edge,
//    r=1 next cycle (latency 1). Memory address -> if MEM_LATENCY=1 same as device, else BUSY
//    with cnt=MEM_LATENCY-1.
//   BUSY: cnt decrements each cycle; mio_en/mar/r_w ignored. At cnt=1 -> access at edge,
//    r=1 next cycle, return IDLE. Total: r rises MEM_LATENCY cycles after acceptance edge.
//   Cycle with r=1 is in IDLE: mio_en=1 there starts a new access (back-to-back allowed).
//  Read: mem_out <= selected data at access edge. Write: array/register updated at access
//   edge; mem_out unchanged.
//  KBSR: [15] ready set when kb_valid & ~KBSR[15] (KBDR <= {8'h00,kb_data}); cleared by
//   completed KBDR read. [14] IE writable; other bits read 0. Same edge KBDR read and
//   kb_valid: read returns old KBDR, new char loaded, [15] stays 1 (set wins).
//  DSR[15]: write DDR clears it, sets disp_valid, disp_data=mdr_in[7:0]. disp_valid &
//   disp_ready -> disp_valid=0, DSR[15]=1 next cycle. DDR write while DSR[15]=0 overwrites
//   DDR, transfer stays pending. DSR[14:0] read 0, not writable.
//  MCR: full 16-bit write; mcr_run=MCR[15]; only reset restores 1.
//  reset mid-BUSY: access aborted, no r, no array write.
// TESTING
//  1 write x3000<=x1234, MEM_LATENCY=3: r pulses 3 cycles after accept; read x3000 -> mem_out
//    x1234 with r, exactly one r per access.
//  2 back-to-back: read issued in r cycle of prior write -> second r exactly 3 cycles later.
//  3 kb_valid with 'A'(x41): KBSR=x8000, kb_ready=0; write KBSR x4000 -> int_req=1; read KBDR
//    -> x0041, int_req and KBSR[15] drop next cycle.
//  4 write DDR x0058: DSR reads x0000, disp_valid=1, disp_data x58; disp_ready 1 cycle -> DSR
//    x8000.
//  5 write MCR x0000 -> mcr_run=0 after r; reset -> mcr_run=1, DSR x8000, KBSR 0.
//  6 reset asserted in BUSY of write x3001<=xBEEF: no r, x3001 keeps old value; read xFE10 -> 0.

Source files
------------

// File: rtl/lc3_mem_io.sv
// lc3_mem_io
//   Memory/IO stage sitting below the LC-3 datapath. Accepts a request
//   (mio_en, r_w, mar, mdr_in) from control and runs the access.
//   - Main memory (addresses below xFE00) takes MEM_LATENCY cycles.
//   - Device registers (xFE00-xFFFF) take one cycle.
//   When the access completes, r pulses for one cycle. For a read, mem_out
//   carries the data. The block also holds the keyboard, display and machine
//   control registers and raises the keyboard interrupt request.
//
// Ports
//   clk, reset            single clock; synchronous active-high reset
//   mio_en, r_w           request strobe; r_w=1 write, 0 read
//   mar, mdr_in           access address and write data
//   mem_out, r            read data (held until the next read completes) and
//                         one-cycle ready pulse per completed access
//   kb_valid/kb_data/kb_ready        keyboard character input
//   disp_valid/disp_data/disp_ready  display character output
//   int_req               keyboard interrupt (KBSR ready & IE)
//   mcr_run               MCR[15]; the machine halts when it is low
//
// Handshakes (keyboard and display): a character moves on a clock edge where
//   the producer's valid and the consumer's ready are both high. Valid is
//   held until that edge, and no combinational path runs from ready to valid.
//
// FSM state is the internal `state` signal (IDLE/BUSY).

module lc3_mem_io #(
    parameter int MEM_LATENCY = 3,
    parameter int MEM_WORDS   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_in,
    output logic [15:0] mem_out,
    output logic        r,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        int_req,
    output logic        mcr_run
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;
    localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    // Request captured at acceptance; used for the whole BUSY period.
    logic [15:0]   lat_addr, lat_data;
    logic          lat_we;

    // The access performed at this edge (acc_go=1), taken from either the
    // live inputs (IDLE) or the latched request (BUSY).
    logic          acc_go, acc_we, acc_dev;
    logic [15:0]   acc_addr, acc_data;
    logic [15:0]   dev_rdata, rd_data;

    logic [15:0]   mem [MEM_WORDS];

    logic          kbsr_ready, kbsr_ie;
    logic [7:0]    kbdr;
    logic [15:0]   ddr, mcr;
    logic          kbdr_rd, kb_load, kbsr_wr, ddr_wr, mcr_wr;

    // Next-state and access selection
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        acc_go   = 1'b0;
        acc_addr = mar;
        acc_data = mdr_in;
        acc_we   = r_w;
        case (state)
            IDLE: begin
                if (mio_en) begin
                    // Devices, and memory with unit latency, complete at the
                    // acceptance edge itself.
                    if ((mar[15:9] == 7'h7F) || (MEM_LATENCY == 1)) begin
                        acc_go = 1'b1;
                    end else begin
                        state_nx = BUSY;
                        cnt_nx   = CW'(MEM_LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                acc_addr = lat_addr;
                acc_data = lat_data;
                acc_we   = lat_we;
                if (cnt == CW'(1)) begin
                    acc_go   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign acc_dev = (acc_addr[15:9] == 7'h7F);

    // Device register read mux; unmapped device addresses read 0.
    always_comb begin
        dev_rdata = 16'h0000;
        case (acc_addr)
            ADDR_KBSR: dev_rdata = {kbsr_ready, kbsr_ie, 14'h0000};
            ADDR_KBDR: dev_rdata = {8'h00, kbdr};
            ADDR_DSR:  dev_rdata = {~disp_valid, 15'h0000};
            ADDR_DDR:  dev_rdata = ddr;
            ADDR_MCR:  dev_rdata = mcr;
            default:   dev_rdata = 16'h0000;
        endcase
    end

    assign rd_data = acc_dev ? dev_rdata : mem[acc_addr[AW-1:0]];

    assign kbdr_rd = acc_go & ~acc_we & (acc_addr == ADDR_KBDR);
    assign kbsr_wr = acc_go &  acc_we & (acc_addr == ADDR_KBSR);
    assign ddr_wr  = acc_go &  acc_we & (acc_addr == ADDR_DDR);
    assign mcr_wr  = acc_go &  acc_we & (acc_addr == ADDR_MCR);
    // A character arriving on the same edge as a KBDR read is loaded: the
    // read sees the old character and the set wins over the clear.
    assign kb_load = kb_valid & (~kbsr_ready | kbdr_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_addr   <= 16'h0000;
            lat_data   <= 16'h0000;
            lat_we     <= 1'b0;
            r          <= 1'b0;
            mem_out    <= 16'h0000;
            kbsr_ready <= 1'b0;
            kbsr_ie    <= 1'b0;
            kbdr       <= 8'h00;
            ddr        <= 16'h0000;
            disp_valid <= 1'b0;
            mcr        <= 16'h8000;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            r     <= acc_go;
            if (state == IDLE && mio_en) begin
                lat_addr <= mar;
                lat_data <= mdr_in;
                lat_we   <= r_w;
            end
            if (acc_go && !acc_we) begin
                mem_out <= rd_data;
            end
            if (kb_load) begin
                kbsr_ready <= 1'b1;
                kbdr       <= kb_data;
            end else if (kbdr_rd) begin
                kbsr_ready <= 1'b0;
            end
            if (kbsr_wr) begin
                kbsr_ie <= acc_data[14];
            end
            // DSR[15] is simply ~disp_valid, so a new DDR write re-arms the
            // transfer even when a previous character is still pending.
            if (ddr_wr) begin
                ddr        <= acc_data;
                disp_valid <= 1'b1;
            end else if (disp_valid && disp_ready) begin
                disp_valid <= 1'b0;
            end
            if (mcr_wr) begin
                mcr <= acc_data;
            end
        end
    end

    // Main memory array: not reset, and never written while reset is high,
    // so an access aborted by reset leaves the array untouched.
    always_ff @(posedge clk) begin
        if (!reset && acc_go && acc_we && !acc_dev) begin
            mem[acc_addr[AW-1:0]] <= acc_data;
        end
    end

    assign kb_ready  = ~kbsr_ready;
    assign int_req   = kbsr_ready & kbsr_ie;
    assign disp_data = ddr[7:0];
    assign mcr_run   = mcr[15];

endmodule

// File: tb/tb_lc3_mem_io.sv
// Testbench for lc3_mem_io: directed scenarios followed by randomized
// transactions, checked against a transaction-level reference model.

module tb_lc3_mem_io;

    localparam int LAT   = 3;
    localparam int WORDS = 4096;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mio_en = 1'b0;
    logic        r_w = 1'b0;
    logic [15:0] mar = 16'h0000;
    logic [15:0] mdr_in = 16'h0000;
    logic [15:0] mem_out;
    logic        r;
    logic        kb_valid = 1'b0;
    logic [7:0]  kb_data = 8'h00;
    logic        kb_ready;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready = 1'b0;
    logic        int_req;
    logic        mcr_run;

    always #5 clk = ~clk;

    lc3_mem_io #(.MEM_LATENCY(LAT), .MEM_WORDS(WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .mio_en     (mio_en),
        .r_w        (r_w),
        .mar        (mar),
        .mdr_in     (mdr_in),
        .mem_out    (mem_out),
        .r          (r),
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .kb_ready   (kb_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready),
        .int_req    (int_req),
        .mcr_run    (mcr_run)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_kb_full, m_kb_ie, m_disp_pend, m_out_known;
    logic [7:0]  m_kb_char;
    logic [15:0] m_ddr, m_mcr, m_out;
    logic [15:0] m_mem [int];

    task automatic model_reset();
        m_kb_full   = 1'b0;
        m_kb_ie     = 1'b0;
        m_kb_char   = 8'h00;
        m_disp_pend = 1'b0;
        m_ddr       = 16'h0000;
        m_mcr       = 16'h8000;
        m_out       = 16'h0000;
        m_out_known = 1'b1;
    endtask

    task automatic model_kb(input logic v, input logic [7:0] d);
        if (v && !m_kb_full) begin
            m_kb_full = 1'b1;
            m_kb_char = d;
        end
    endtask

    task automatic model_access(input logic we, input logic [15:0] a, input logic [15:0] d);
        int idx = int'(a) % WORDS;
        if (a >= 16'hFE00) begin
            if (!we) begin
                m_out_known = 1'b1;
                case (a)
                    16'hFE00: m_out = m_kb_full ? (m_kb_ie ? 16'hC000 : 16'h8000)
                                                : (m_kb_ie ? 16'h4000 : 16'h0000);
                    16'hFE02: begin
                        m_out = {8'h00, m_kb_char};
                        m_kb_full = 1'b0;
                    end
                    16'hFE04: m_out = m_disp_pend ? 16'h0000 : 16'h8000;
                    16'hFE06: m_out = m_ddr;
                    16'hFFFE: m_out = m_mcr;
                    default:  m_out = 16'h0000;
                endcase
            end else begin
                case (a)
                    16'hFE00: m_kb_ie = d[14];
                    16'hFE06: begin
                        m_ddr = d;
                        m_disp_pend = 1'b1;
                    end
                    16'hFFFE: m_mcr = d;
                    default: ;
                endcase
            end
        end else if (we) begin
            m_mem[idx] = d;
        end else if (m_mem.exists(idx)) begin
            m_out = m_mem[idx];
            m_out_known = 1'b1;
        end else begin
            m_out_known = 1'b0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        if (m_out_known) check({tag, " mem_out"}, mem_out, m_out);
        check({tag, " kb_ready"}, 16'(kb_ready), 16'(!m_kb_full));
        check({tag, " int_req"}, 16'(int_req), 16'(m_kb_full & m_kb_ie));
        check({tag, " disp_valid"}, 16'(disp_valid), 16'(m_disp_pend));
        if (m_disp_pend) check({tag, " disp_data"}, 16'(disp_data), {8'h00, m_ddr[7:0]});
        check({tag, " mcr_run"}, 16'(mcr_run), 16'(m_mcr[15]));
    endtask

    // Issues one access, waits for r (bounded) and checks latency and outputs.
    // Returns in the r cycle so the caller may issue the next access at once.
    // kb_valid/kb_data set by the caller are applied on the acceptance edge.
    task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d,
                          input string tag);
        int lat;
        int exp_lat;
        exp_lat = (a >= 16'hFE00) ? 1 : LAT;
        mio_en = 1'b1;
        r_w    = we;
        mar    = a;
        mdr_in = d;
        model_access(we, a, d);
        model_kb(kb_valid, kb_data);
        cycle();
        mio_en   = 1'b0;
        kb_valid = 1'b0;
        lat = 1;
        while (r !== 1'b1 && lat < 20) begin
            // Request inputs are don't-care while the access is in flight.
            mio_en = 1'($urandom);
            r_w    = 1'($urandom);
            mar    = 16'($urandom);
            mdr_in = 16'($urandom);
            cycle();
            lat++;
        end
        mio_en = 1'b0;
        check({tag, " latency"}, 16'(lat), 16'(exp_lat));
        check_state(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
            check("idle r", 16'(r), 16'h0000);
        end
    endtask

    task automatic kb_event(input logic [7:0] d);
        kb_valid = 1'b1;
        kb_data  = d;
        model_kb(1'b1, d);
        cycle();
        kb_valid = 1'b0;
        check("kb_event r", 16'(r), 16'h0000);
        check_state("kb_event");
    endtask

    task automatic disp_event();
        disp_ready = 1'b1;
        if (m_disp_pend) m_disp_pend = 1'b0;
        cycle();
        disp_ready = 1'b0;
        check("disp_event r", 16'(r), 16'h0000);
        check_state("disp_event");
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        mio_en = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        model_reset();
        check("reset r", 16'(r), 16'h0000);
        check("reset mem_out", mem_out, 16'h0000);
        check_state("reset");
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] pool [8];
    logic [15:0] dev_rd [7];
    logic [15:0] dev_wr [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        pool   = '{16'h0000, 16'h0005, 16'h1005, 16'h3000, 16'h3001,
                   16'h0FFF, 16'h1FFF, 16'hFDFF};
        dev_rd = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFFFE, 16'hFE08,
                   16'hFF00, 16'hFFFF};
        dev_wr = '{16'hFE00, 16'hFE06, 16'hFFFE, 16'hFE04, 16'hFE10};

        do_reset();
        check("reset kb_ready", 16'(kb_ready), 16'h0001);
        check("reset mcr_run", 16'(mcr_run), 16'h0001);
        access(1'b0, 16'hFE04, 16'h0, "reset dsr");
        check("reset dsr value", mem_out, 16'h8000);

        // 1: memory write then read, single r pulse each
        access(1'b1, 16'h3000, 16'h1234, "t1 write");
        idle(2);
        access(1'b0, 16'h3000, 16'h0, "t1 read");
        check("t1 read value", mem_out, 16'h1234);
        idle(1);

        // 2: back-to-back, read issued in the write's r cycle
        access(1'b1, 16'h3010, 16'h5555, "t2 write");
        access(1'b0, 16'h3010, 16'h0, "t2 read");
        check("t2 read value", mem_out, 16'h5555);
        access(1'b1, 16'h1005, 16'h0A0A, "t2 alias write");
        access(1'b0, 16'h0005, 16'h0, "t2 alias read");
        check("t2 alias value", mem_out, 16'h0A0A);
        access(1'b1, 16'hFDFF, 16'h7777, "t2 top write");
        access(1'b0, 16'hFDFF, 16'h0, "t2 top read");
        check("t2 top value", mem_out, 16'h7777);
        access(1'b1, 16'h3000, 16'h9999, "t2 write holds mem_out");
        check("t2 mem_out held", mem_out, 16'h7777);
        idle(1);

        // 3: keyboard
        kb_event(8'h41);
        check("t3 kb_ready", 16'(kb_ready), 16'h0000);
        access(1'b0, 16'hFE00, 16'h0, "t3 kbsr");
        check("t3 kbsr value", mem_out, 16'h8000);
        access(1'b1, 16'hFE00, 16'h4000, "t3 ie");
        check("t3 int_req", 16'(int_req), 16'h0001);
        access(1'b0, 16'hFE02, 16'h0, "t3 kbdr");
        check("t3 kbdr value", mem_out, 16'h0041);
        check("t3 int_req drop", 16'(int_req), 16'h0000);
        check("t3 kb_ready back", 16'(kb_ready), 16'h0001);
        kb_event(8'h43);
        kb_valid = 1'b1;
        kb_data  = 8'h42;
        access(1'b0, 16'hFE02, 16'h0, "t3 same edge");
        check("t3 same edge old", mem_out, 16'h0043);
        check("t3 same edge full", 16'(kb_ready), 16'h0000);
        access(1'b0, 16'hFE02, 16'h0, "t3 new char");
        check("t3 new char value", mem_out, 16'h0042);
        idle(1);

        // 4: display
        access(1'b1, 16'hFE06, 16'h0058, "t4 ddr");
        check("t4 disp_valid", 16'(disp_valid), 16'h0001);
        check("t4 disp_data", 16'(disp_data), 16'h0058);
        access(1'b0, 16'hFE04, 16'h0, "t4 dsr busy");
        check("t4 dsr busy value", mem_out, 16'h0000);
        disp_event();
        access(1'b0, 16'hFE04, 16'h0, "t4 dsr ready");
        check("t4 dsr ready value", mem_out, 16'h8000);
        access(1'b1, 16'hFE06, 16'h0061, "t4 ddr a");
        access(1'b1, 16'hFE06, 16'h0062, "t4 ddr b");
        check("t4 overwrite data", 16'(disp_data), 16'h0062);
        disp_event();
        check("t4 consumed", 16'(disp_valid), 16'h0000);

        // 5: MCR
        access(1'b1, 16'hFFFE, 16'h0000, "t5 mcr");
        check("t5 mcr_run low", 16'(mcr_run), 16'h0000);
        kb_event(8'h33);
        do_reset();
        check("t5 mcr_run high", 16'(mcr_run), 16'h0001);
        access(1'b0, 16'hFE04, 16'h0, "t5 dsr");
        check("t5 dsr value", mem_out, 16'h8000);
        access(1'b0, 16'hFE00, 16'h0, "t5 kbsr");
        check("t5 kbsr value", mem_out, 16'h0000);

        // 6: reset during BUSY aborts the write
        access(1'b1, 16'h3001, 16'h1111, "t6 setup");
        idle(1);
        mio_en = 1'b1;
        r_w    = 1'b1;
        mar    = 16'h3001;
        mdr_in = 16'hBEEF;
        cycle();
        mio_en = 1'b0;
        reset  = 1'b1;
        cycle();
        reset = 1'b0;
        model_reset();
        idle(4);
        access(1'b0, 16'h3001, 16'h0, "t6 read");
        check("t6 kept value", mem_out, 16'h1111);
        access(1'b0, 16'hFE10, 16'h0, "t6 unmapped");
        check("t6 unmapped value", mem_out, 16'h0000);
        idle(1);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: access(1'b1, pool[$urandom_range(0, 7)], 16'($urandom), "rnd mem wr");
                3, 4:    access(1'b0, pool[$urandom_range(0, 7)], 16'h0, "rnd mem rd");
                5:       access(1'b0, dev_rd[$urandom_range(0, 6)], 16'h0, "rnd dev rd");
                6:       access(1'b1, dev_wr[$urandom_range(0, 4)], 16'($urandom), "rnd dev wr");
                7:       kb_event(8'($urandom));
                8: begin
                    kb_valid = 1'b1;
                    kb_data  = 8'($urandom);
                    access(1'b0, 16'hFE02, 16'h0, "rnd kbdr race");
                end
                default: disp_event();
            endcase
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
